// File: rtl/dmem_pkg.sv
// dmem_pkg: FSM state type, default configuration constants and a small index-width helper
// shared by the dmem_banked slice.
package dmem_pkg;

   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_LO_DEPTH    = 64;
   localparam int unsigned DEF_HI_DEPTH    = 4096;
   localparam int unsigned DEF_LO_LIMIT    = 256;
   localparam int unsigned DEF_WAIT_CYCLES = 0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   // Word-index width for a bank; at least one bit so a 1-deep bank still has an address.
   function automatic int unsigned idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_banked_if.sv
// dmem_banked_if: request/response bus between a core-side master and the dmem_banked slave.
interface dmem_banked_if #(
   parameter int unsigned DATA_W = dmem_pkg::DEF_DATA_W
);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [31:0]           req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_rdata;
   logic                  resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/dmem_bank.sv
// dmem_bank: single-port synchronous RAM with byte-enable writes and a registered read port.
// Contents are never reset; rdata only changes on an enabled read.
module dmem_bank
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_LO_DEPTH,
   parameter int unsigned AW     = idx_w(DEPTH)
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [DATA_W/8-1:0] be,
   input  logic [AW-1:0]       addr,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata
);

   localparam int unsigned BE_W = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Byte-masked write or registered read on an enabled cycle.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
               if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_banked.sv
// dmem_banked: two-bank data memory (low bank below LO_LIMIT, high bank above) with a
// fixed-latency response of WAIT_CYCLES+1 cycles after each accept.
// Optional build macro DMEM_BOUNDS_CHECK_EN: out-of-range indices are flagged on resp_err and
// suppressed instead of wrapping. Bank depths are expected to be powers of two so wrapping is a
// plain truncation of the word index.
module dmem_banked
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned LO_DEPTH    = DEF_LO_DEPTH,
   parameter int unsigned HI_DEPTH    = DEF_HI_DEPTH,
   parameter int unsigned LO_LIMIT    = DEF_LO_LIMIT,
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic         clk,
   input  logic         rst,
   dmem_banked_if.slave bus
);

   localparam int unsigned LO_AW     = idx_w(LO_DEPTH);
   localparam int unsigned HI_AW     = idx_w(HI_DEPTH);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              sel_hi_q, we_q, err_q;
   logic [DATA_W-1:0] hold_q, rd_now, lo_rdata, hi_rdata;
   logic              accept, sel_hi, oob, acc_err, lo_en, hi_en;
   logic [31:0]       lo_word, hi_off, hi_word;

   assign bus.req_ready = (state_q == StIdle) && !rst;
   assign accept        = bus.req_valid && bus.req_ready;

   // Bank select and word indices; address bits [1:0] drop out of the shift.
   always_comb begin
      sel_hi  = bus.req_addr >= 32'(LO_LIMIT);
      lo_word = bus.req_addr >> 2;
      hi_off  = bus.req_addr - 32'(LO_LIMIT);
      hi_word = hi_off >> 2;
      oob     = sel_hi ? (hi_word >= 32'(HI_DEPTH)) : (lo_word >= 32'(LO_DEPTH));
   end

`ifdef DMEM_BOUNDS_CHECK_EN
   assign acc_err = oob;
`else
   logic unused_oob;
   assign acc_err    = 1'b0;
   assign unused_oob = oob;
`endif

   // Store happens and load data is captured at the accept edge; a flagged access touches nothing.
   assign lo_en = accept && !sel_hi && !acc_err;
   assign hi_en = accept &&  sel_hi && !acc_err;

   dmem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (LO_DEPTH),
      .AW     (LO_AW)
   ) u_lo_bank (
      .clk   (clk),
      .en    (lo_en),
      .we    (bus.req_we),
      .be    (bus.req_be),
      .addr  (lo_word[LO_AW-1:0]),
      .wdata (bus.req_wdata),
      .rdata (lo_rdata)
   );

   dmem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (HI_DEPTH),
      .AW     (HI_AW)
   ) u_hi_bank (
      .clk   (clk),
      .en    (hi_en),
      .we    (bus.req_we),
      .be    (bus.req_be),
      .addr  (hi_word[HI_AW-1:0]),
      .wdata (bus.req_wdata),
      .rdata (hi_rdata)
   );

   // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE, WAIT timed by a down-counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = StResp;
               cnt_d   = 4'd0;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and counter registers; reset aborts any in-flight request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Per-request attributes latched at accept, plus the held copy of the last response data.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_hi_q <= 1'b0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         hold_q   <= '0;
      end else begin
         if (accept) begin
            sel_hi_q <= sel_hi;
            we_q     <= bus.req_we;
            err_q    <= acc_err;
         end
         if (state_q == StResp) hold_q <= rd_now;
      end
   end

   // Bank read registers already hold the data during RESP; stores and errors answer zero.
   assign rd_now = (!we_q && !err_q) ? (sel_hi_q ? hi_rdata : lo_rdata) : '0;

   assign bus.resp_valid = (state_q == StResp) && !rst;
   assign bus.resp_rdata = rst ? '0 : ((state_q == StResp) ? rd_now : hold_q);

`ifdef DMEM_BOUNDS_CHECK_EN
   assign bus.resp_err = (state_q == StResp) && !rst && err_q;
`else
   assign bus.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_banked.sv
// tb_dmem_banked: directed vector table against a zero-wait instance, plus hand-written
// sequences against a three-wait instance for back-to-back accepts and reset abort.
module tb_dmem_banked;

   logic clk = 1'b0;
   logic rst0, rst3;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dmem_banked_if #(.DATA_W(32)) bus0 ();
   dmem_banked_if #(.DATA_W(32)) bus3 ();

   dmem_banked #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
   dmem_banked #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

`ifdef DMEM_BOUNDS_CHECK_EN
   localparam logic        OOB_ERR   = 1'b1;
   localparam logic [31:0] OOB_LD    = 32'h0;
   localparam logic [31:0] HI0_AFTER = 32'h1122CCDD;
`else
   localparam logic        OOB_ERR   = 1'b0;
   localparam logic [31:0] OOB_LD    = 32'hCAFEF00D;
   localparam logic [31:0] HI0_AFTER = 32'hCAFEF00D;
`endif

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
      string       name;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input int which, input logic v, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      if (which == 0) begin
         bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = addr;
         bus0.req_wdata = wdata; bus0.req_be = be;
      end else begin
         bus3.req_valid = v; bus3.req_we = we; bus3.req_addr = addr;
         bus3.req_wdata = wdata; bus3.req_be = be;
      end
   endtask

   function automatic logic rdy(input int which);
      return (which == 0) ? bus0.req_ready : bus3.req_ready;
   endfunction

   function automatic logic rvld(input int which);
      return (which == 0) ? bus0.resp_valid : bus3.resp_valid;
   endfunction

   // One request: wait (bounded) for ready, accept, then count cycles until resp_valid.
   task automatic xact(input int which, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rdata, output logic err, output int lat);
      int n;
      @(negedge clk);
      drive(which, 1'b1, we, addr, wdata, be);
      n = 0;
      while (!rdy(which) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", {31'b0, rdy(which)}, 32'd1);
      @(negedge clk);
      drive(which, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      lat = 1;
      while (!rvld(which) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rdata = (which == 0) ? bus0.resp_rdata : bus3.resp_rdata;
      err   = (which == 0) ? bus0.resp_err : bus3.resp_err;
   endtask

   // Called at a negedge where dut3 will accept on the next edge with valid held high.
   task automatic pipe3(input string nm, input logic [31:0] exp_rdata);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk({nm, "_ready_low"}, {31'b0, bus3.req_ready}, 32'd0);
         chk({nm, "_resp_valid"}, {31'b0, bus3.resp_valid}, (i == 4) ? 32'd1 : 32'd0);
      end
      chk({nm, "_rdata"}, bus3.resp_rdata, exp_rdata);
      @(negedge clk);
      chk({nm, "_ready_back"}, {31'b0, bus3.req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        seen;

      vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0,    "st_lo_10"};
      vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0,    "ld_lo_10"};
      vecs[2]  = '{1'b1, 32'h100,  32'h11223344, 4'hF, 32'h0,        1'b0,    "st_hi_0"};
      vecs[3]  = '{1'b1, 32'h100,  32'hAABBCCDD, 4'h3, 32'h0,        1'b0,    "st_hi_0_be3"};
      vecs[4]  = '{1'b0, 32'h100,  32'h0,        4'h0, 32'h1122CCDD, 1'b0,    "ld_hi_0"};
      vecs[5]  = '{1'b0, 32'h103,  32'h0,        4'h0, 32'h1122CCDD, 1'b0,    "ld_hi_0_unaligned"};
      vecs[6]  = '{1'b1, 32'hFC,   32'h5A5A0001, 4'hF, 32'h0,        1'b0,    "st_lo_top"};
      vecs[7]  = '{1'b0, 32'hFF,   32'h0,        4'h0, 32'h5A5A0001, 1'b0,    "ld_lo_top_ff"};
      vecs[8]  = '{1'b0, 32'h0FC,  32'h0,        4'h0, 32'h5A5A0001, 1'b0,    "ld_lo_top_fc"};
      vecs[9]  = '{1'b1, 32'h14,   32'h12345678, 4'hF, 32'h0,        1'b0,    "st_lo_14"};
      vecs[10] = '{1'b1, 32'h14,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0,    "st_lo_14_be0"};
      vecs[11] = '{1'b1, 32'h14,   32'hAB000000, 4'h8, 32'h0,        1'b0,    "st_lo_14_be8"};
      vecs[12] = '{1'b0, 32'h14,   32'h0,        4'h0, 32'hAB345678, 1'b0,    "ld_lo_14"};
      vecs[13] = '{1'b1, 32'h40FC, 32'h76543210, 4'hF, 32'h0,        1'b0,    "st_hi_last"};
      vecs[14] = '{1'b0, 32'h40FC, 32'h0,        4'h0, 32'h76543210, 1'b0,    "ld_hi_last"};
      vecs[15] = '{1'b1, 32'h4100, 32'hCAFEF00D, 4'hF, 32'h0,        OOB_ERR, "st_hi_oob"};
      vecs[16] = '{1'b0, 32'h4100, 32'h0,        4'h0, OOB_LD,       OOB_ERR, "ld_hi_oob"};
      vecs[17] = '{1'b0, 32'h100,  32'h0,        4'h0, HI0_AFTER,    1'b0,    "ld_hi_0_after_oob"};
      vecs[18] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0,    "ld_lo_10_again"};

      rst0 = 1'b1;
      rst3 = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

      // Reset state, sampled with rst still asserted and valid requested.
      repeat (2) @(negedge clk);
      bus0.req_valid = 1'b1;
      #1;
      chk("rst_ready0", {31'b0, bus0.req_ready}, 32'd0);
      chk("rst_ready3", {31'b0, bus3.req_ready}, 32'd0);
      chk("rst_resp_valid0", {31'b0, bus0.resp_valid}, 32'd0);
      chk("rst_rdata0", bus0.resp_rdata, 32'h0);
      chk("rst_err0", {31'b0, bus0.resp_err}, 32'd0);
      bus0.req_valid = 1'b0;
      rst0 = 1'b0;
      rst3 = 1'b0;
      @(negedge clk);
      chk("post_rst_ready0", {31'b0, bus0.req_ready}, 32'd1);

      // Vector table on the zero-wait instance.
      for (int i = 0; i < 19; i++) begin
         xact(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
         chk({vecs[i].name, "_latency"}, 32'(lat), 32'd1);
         chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
         chk({vecs[i].name, "_err"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
         @(negedge clk);
         chk({vecs[i].name, "_strobe_1cyc"}, {31'b0, bus0.resp_valid}, 32'd0);
      end

      // Three-wait instance: valid held high across two back-to-back requests.
      @(negedge clk);
      drive(3, 1'b1, 1'b1, 32'h20, 32'h0BADCAFE, 4'hF);
      chk("w3_idle_ready", {31'b0, bus3.req_ready}, 32'd1);
      pipe3("w3_st", 32'h0);
      drive(3, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      pipe3("w3_ld", 32'h0BADCAFE);
      drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("w3_hold_valid", {31'b0, bus3.resp_valid}, 32'd0);
      chk("w3_hold_rdata", bus3.resp_rdata, 32'h0BADCAFE);

      // Reset during WAIT aborts the response; the store done at accept survives.
      drive(3, 1'b1, 1'b1, 32'h24, 32'h13579BDF, 4'hF);
      @(negedge clk);
      drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk("abort_in_wait_ready", {31'b0, bus3.req_ready}, 32'd0);
      chk("abort_rdata_held", bus3.resp_rdata, 32'h0BADCAFE);
      rst3 = 1'b1;
      @(negedge clk);
      chk("abort_rst_ready", {31'b0, bus3.req_ready}, 32'd0);
      chk("abort_rst_valid", {31'b0, bus3.resp_valid}, 32'd0);
      chk("abort_rst_rdata", bus3.resp_rdata, 32'h0);
      @(negedge clk);
      rst3 = 1'b0;
      @(negedge clk);
      chk("abort_ready_after_rst", {31'b0, bus3.req_ready}, 32'd1);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus3.resp_valid) seen = 1'b1;
      end
      chk("abort_no_resp", {31'b0, seen}, 32'd0);
      xact(3, 1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat);
      chk("abort_store_kept", rd, 32'h13579BDF);
      chk("w3_latency", 32'(lat), 32'd4);
      xact(3, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      chk("abort_old_data_kept", rd, 32'h0BADCAFE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_banked.md
DMEM_BANKED -- requirements
Module: dmem_banked

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width (multiple of 8).
REQ-002 SHALL have parameter LO_DEPTH, default 64, low-bank depth in words.
REQ-003 SHALL have parameter HI_DEPTH, default 4096, high-bank depth in words.
REQ-004 SHALL have parameter LO_LIMIT, default 256, first byte address of the high bank.
REQ-005 SHALL have parameter WAIT_CYCLES, default 0, extra response wait states (0..15).
REQ-006 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port req_valid  input  1  request present.
REQ-009 SHALL have port req_ready  output  1  request accepted this cycle if req_valid.
REQ-010 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port req_addr  input  32  byte address.
REQ-012 SHALL have port req_wdata  input  DATA_W  store data.
REQ-013 SHALL have port req_be  input  DATA_W/8  store byte enables.
REQ-014 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-015 SHALL have port resp_rdata  output  DATA_W  load data; 0 for stores.
REQ-016 SHALL have port resp_err  output  1  out-of-range access (DMEM_BOUNDS_CHECK_EN only; tied 0 otherwise).

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = (state==IDLE) && !rst.
REQ-018 SHALL accept a request on the edge where req_valid && req_ready; IDLE goes to WAIT, or directly to RESP when WAIT_CYCLES==0.
REQ-019 SHALL hold WAIT for exactly WAIT_CYCLES cycles via a down-counter, then enter RESP.
REQ-020 SHALL assert resp_valid for exactly the one cycle in RESP; load latency is WAIT_CYCLES+1 cycles from the accept edge.
REQ-021 SHALL select the low bank when req_addr < LO_LIMIT (word index req_addr>>2), else the high bank (index (req_addr-LO_LIMIT)>>2).
REQ-022 SHALL ignore req_addr[1:0]; accesses are word-aligned.
REQ-023 SHALL perform the store at the accept edge, writing only the bytes with req_be set; req_be==0 stores nothing but still responds.
REQ-024 SHALL capture load data at the accept edge and hold resp_rdata stable until the next response.
REQ-025 SHALL truncate an out-of-range index modulo bank depth (wrap-around) when DMEM_BOUNDS_CHECK_EN is undefined.
REQ-026 SHALL ignore req_valid outside IDLE; minimum spacing between accepts is WAIT_CYCLES+2 cycles.

Reset
REQ-027 SHALL, while rst is high, force state=IDLE, counter=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-028 SHALL abort an in-flight request on rst without issuing its response; a store already performed at its accept edge stays written.
REQ-029 SHALL NOT clear memory contents on reset.

Configuration
REQ-030 SHALL, with DMEM_BOUNDS_CHECK_EN defined, suppress any store whose index is >= bank depth, return resp_rdata=0 and assert resp_err with resp_valid for that access.
REQ-031 SHALL, without DMEM_BOUNDS_CHECK_EN, wrap per REQ-025 and drive resp_err constant 0.

Structure
REQ-032 SHALL place the FSM state enum and the default parameter constants in package dmem_pkg.
REQ-033 SHALL instantiate sub-module dmem_bank (single-port synchronous RAM, byte-enable write, registered read) twice: low bank and high bank.

Verification
REQ-034 SHALL cover: WAIT_CYCLES=0, store 0xDEADBEEF at 0x10 with be=0xF, then load 0x10 -> resp_valid 1 cycle after each accept, rdata 0xDEADBEEF.
REQ-035 SHALL cover: store 0x11223344 at 0x100 with be=0xF, then store 0xAABBCCDD with be=0x3, then load 0x100 -> rdata 0x1122CCDD, high-bank index 0.
REQ-036 SHALL cover: WAIT_CYCLES=3, hold req_valid high continuously -> req_ready low for 4 cycles after each accept, resp_valid exactly 4 cycles after the accept.
REQ-037 SHALL cover: rst pulsed during WAIT -> no resp_valid, req_ready=1 on the first cycle after rst drops, earlier store data intact.
REQ-038 SHALL cover: LO_DEPTH=64, load 0xFC then 0x0FC (no macro) -> same word; with DMEM_BOUNDS_CHECK_EN, store at LO_LIMIT+4*HI_DEPTH -> resp_err=1, rdata 0, no write.
